// File: rtl/csr_tohost_drain.sv
// Drains the CSR_TOHOST write stream through a small FIFO to a valid/ready host port and
// decodes the riscv-tests end-of-test write into sticky done/pass/fail_code status.
module csr_tohost_drain #(
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       stall_i,
  input  logic                       csr_we_i,
  input  logic [31:0]                wb_data_i,
  output logic                       host_valid_o,
  input  logic                       host_ready_i,
  output logic [31:0]                host_data_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       overflow_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic [30:0]                fail_code_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     mem_q [Depth];
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [30:0]     fail_code_q, fail_code_d;

  logic push, pop, full, empty, accept;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CntW'(Depth));
  assign push   = csr_we_i && !stall_i;
  assign pop    = !empty && host_ready_i;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign accept = push && (!full || pop);

  always_comb begin
    rptr_d      = rptr_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_code_d = fail_code_q;

    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    if (accept) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (push && !accept) begin
      overflow_d = 1'b1;
    end

    if (accept && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !accept) begin
      count_d = count_q - CntW'(1);
    end

    // First end-of-test write wins, whether or not its value was queued.
    if (push && wb_data_i[0] && !done_q) begin
      done_d      = 1'b1;
      pass_d      = (wb_data_i == 32'h1);
      fail_code_d = wb_data_i[31:1];
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      rptr_q      <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_code_q <= '0;
    end else begin
      if (accept) begin
        mem_q[wptr_q] <= wb_data_i;
      end
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_code_q <= fail_code_d;
    end
  end

  assign host_valid_o = !empty;
  assign host_data_o  = empty ? 32'h0 : mem_q[rptr_q];
  assign count_o      = count_q;
  assign overflow_o   = overflow_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign fail_code_o  = fail_code_q;

endmodule

// File: tb/tb_csr_tohost_drain.sv
// Directed plus randomized bench for csr_tohost_drain against a queue-based reference model.
module tb_csr_tohost_drain;

  localparam int unsigned Depth = 4;
  localparam int unsigned CntW  = $clog2(Depth) + 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            stall, csr_we, host_ready;
  logic [31:0]     wb_data;
  logic            host_valid;
  logic [31:0]     host_data;
  logic [CntW-1:0] count;
  logic            overflow, done, pass;
  logic [30:0]     fail_code;

  always #5 clk = ~clk;

  csr_tohost_drain #(.Depth(Depth)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .stall_i      (stall),
    .csr_we_i     (csr_we),
    .wb_data_i    (wb_data),
    .host_valid_o (host_valid),
    .host_ready_i (host_ready),
    .host_data_o  (host_data),
    .count_o      (count),
    .overflow_o   (overflow),
    .done_o       (done),
    .pass_o       (pass),
    .fail_code_o  (fail_code)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: FIFO contents as a queue plus sticky status.
  logic [31:0] mq[$];
  logic        m_ovf, m_done, m_pass;
  logic [30:0] m_fc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_data;
    exp_data = (mq.size() > 0) ? mq[0] : 32'h0;
    chk("host_valid", {31'b0, host_valid}, {31'b0, mq.size() > 0});
    chk("host_data", host_data, exp_data);
    chk("count", {{(32-CntW){1'b0}}, count}, mq.size());
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    chk("done", {31'b0, done}, {31'b0, m_done});
    chk("pass", {31'b0, pass}, {31'b0, m_pass});
    chk("fail_code", {1'b0, fail_code}, {1'b0, m_fc});
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf  = 1'b0;
    m_done = 1'b0;
    m_pass = 1'b0;
    m_fc   = '0;
  endtask

  // One clock cycle: apply inputs, advance model, check just after the edge.
  task automatic step(input logic we, input logic st, input logic [31:0] d, input logic rdy);
    bit do_push, do_pop, was_full;
    csr_we     = we;
    stall      = st;
    wb_data    = d;
    host_ready = rdy;
    do_push  = we && !st;
    do_pop   = (mq.size() > 0) && rdy;
    was_full = (mq.size() == Depth);
    if (do_push && d[0] && !m_done) begin
      m_done = 1'b1;
      m_pass = (d == 32'h1);
      m_fc   = d[31:1];
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      if (was_full && !do_pop) m_ovf = 1'b1;
      else mq.push_back(d);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    csr_we     = 1'b0;
    stall      = 1'b0;
    wb_data    = '0;
    host_ready = 1'b0;
    reset_n    = 1'b0;
    model_clear();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_all();
  endtask

  initial begin
    reset_n = 1'b1;
    #2;
    do_reset();

    // 1: end-of-test pass write
    step(1'b1, 1'b0, 32'h1, 1'b0);
    do_reset();

    // 2: stalled write ignored
    step(1'b1, 1'b1, 32'h5, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    do_reset();

    // 3: overflow then drain
    step(1'b1, 1'b0, 32'd10, 1'b0);
    step(1'b1, 1'b0, 32'd20, 1'b0);
    step(1'b1, 1'b0, 32'd30, 1'b0);
    step(1'b1, 1'b0, 32'd40, 1'b0);
    step(1'b1, 1'b0, 32'd50, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    do_reset();

    // 4: push and pop together while full
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h100 + i * 2, 1'b0);
    step(1'b1, 1'b0, 32'hAA, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    do_reset();

    // 5: first end write wins
    step(1'b1, 1'b0, 32'h7, 1'b0);
    step(1'b1, 1'b0, 32'h1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    do_reset();

    // 6: asynchronous reset mid-cycle with three entries queued
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h40 + i * 2, 1'b0);
    #2;
    reset_n = 1'b0;
    csr_we  = 1'b0;
    model_clear();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_all();
    step(1'b1, 1'b0, 32'hBEE0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic with occasional resets; ready probability alternates by phase.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] d;
      logic        rdy;
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        d    = $urandom;
        d[0] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 31) == 0) d = 32'h1;
        rdy  = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        step($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, d, rdy);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
